// File: rtl/if_stage_pkg.sv
// Shared encodings for the fetch stage: CMP result codes, branch kinds and
// reset/memory defaults, plus the branch-condition rule used by npc_sel.
`default_nettype none

package if_stage_pkg;

    localparam logic [1:0] CMP_EQ  = 2'b00;
    localparam logic [1:0] CMP_GT  = 2'b01;
    localparam logic [1:0] CMP_LT  = 2'b10;
    localparam logic [1:0] CMP_BAD = 2'b11;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BGEZ = 3'd3,
        BR_BGTZ = 3'd4,
        BR_BLEZ = 3'd5,
        BR_BLTZ = 3'd6,
        BR_RSVD = 3'd7
    } br_type_e;

    localparam logic [31:0] DEF_PC_RESET = 32'h0000_3000;
    localparam int          DEF_IM_WORDS = 4096;

    // An illegal CMP code (11) never satisfies any branch, including bne.
    function automatic logic branch_cond(input br_type_e kind, input logic [1:0] cmp);
        logic hit;
        hit = 1'b0;
        case (kind)
            BR_BEQ:  hit = (cmp == CMP_EQ);
            BR_BNE:  hit = (cmp != CMP_EQ);
            BR_BGEZ: hit = (cmp != CMP_LT);
            BR_BGTZ: hit = (cmp == CMP_GT);
            BR_BLEZ: hit = (cmp != CMP_GT);
            BR_BLTZ: hit = (cmp == CMP_LT);
            default: hit = 1'b0;
        endcase
        return hit && (cmp != CMP_BAD);
    endfunction

endpackage

`default_nettype wire

// File: rtl/if_stage_npc_sel.sv
// Next-PC select: evaluates the D-stage control transfer and picks the target
// (jreg > jump > branch) or the sequential PC+4.
`default_nettype none

module if_stage_npc_sel
    import if_stage_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] d_pc,
    input  logic [25:0] d_instr_idx,
    input  logic [2:0]  br_type,
    input  logic [1:0]  cmp,
    input  logic        jump,
    input  logic        jreg,
    input  logic [31:0] ra,
    output logic        taken,
    output logic [31:0] npc
);

    logic [31:0] d_pc4;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;
    logic        br_hit;

    always_comb begin
        d_pc4  = d_pc + 32'd4;
        br_tgt = d_pc4 + {{14{d_instr_idx[15]}}, d_instr_idx[15:0], 2'b00};
        j_tgt  = {d_pc4[31:28], d_instr_idx, 2'b00};
        br_hit = branch_cond(br_type_e'(br_type), cmp);

        taken = 1'b1;
        npc   = pc + 32'd4;
        if (jreg) begin
            npc = ra;
        end else if (jump) begin
            npc = j_tgt;
        end else if (br_hit) begin
            npc = br_tgt;
        end else begin
            taken = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// Fetch stage with F/D pipeline register: holds the PC, latches the fetched
// word, applies D-stage redirects and keeps redirect/stall perf counters.
`default_nettype none

module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] PC_RESET = DEF_PC_RESET,
    parameter int          IM_WORDS = DEF_IM_WORDS
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [2:0]  br_type,
    input  logic [1:0]  cmp,
    input  logic        jump,
    input  logic        jreg,
    input  logic [31:0] ra,
    output logic [31:0] im_addr,
    input  logic [31:0] im_instr,
    output logic [31:0] D_instr,
    output logic [31:0] D_pc,
    output logic [31:0] D_pc8,
    output logic        f_err,
    output logic [31:0] taken_cnt,
    output logic [31:0] stall_cnt
);

    // 33-bit bound so a memory ending exactly at 2^32 still compares correctly.
    localparam logic [32:0] FETCH_END = {1'b0, PC_RESET} + 33'(4 * IM_WORDS);

    logic [31:0] pc;
    logic [31:0] npc;
    logic        redirect;
    logic        fetch_ok;

    if_stage_npc_sel u_npc_sel (
        .pc          (pc),
        .d_pc        (D_pc),
        .d_instr_idx (D_instr[25:0]),
        .br_type     (br_type),
        .cmp         (cmp),
        .jump        (jump),
        .jreg        (jreg),
        .ra          (ra),
        .taken       (redirect),
        .npc         (npc)
    );

    always_comb begin
        fetch_ok = (pc[1:0] == 2'b00) && (pc >= PC_RESET) && ({1'b0, pc} < FETCH_END);
    end

    assign im_addr = pc;
    assign D_pc8   = D_pc + 32'd8;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc        <= PC_RESET;
            D_instr   <= 32'd0;
            D_pc      <= 32'd0;
            f_err     <= 1'b0;
            taken_cnt <= 32'd0;
            stall_cnt <= 32'd0;
        end else if (stall) begin
            stall_cnt <= stall_cnt + 32'd1;
        end else begin
            pc      <= npc;
            D_instr <= fetch_ok ? im_instr : 32'd0;
            D_pc    <= pc;
            f_err   <= ~fetch_ok;
            if (redirect) begin
                taken_cnt <= taken_cnt + 32'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios followed by random
// control traffic, compared against an arithmetic model of the fetch rules.
`default_nettype none

module tb_if_stage;

    localparam logic [31:0] PCR   = 32'h0000_3000;
    localparam int          WORDS = 4096;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [2:0]  br_type;
    logic [1:0]  cmp;
    logic        jump;
    logic        jreg;
    logic [31:0] ra;
    logic [31:0] im_addr;
    logic [31:0] im_instr;
    logic [31:0] D_instr;
    logic [31:0] D_pc;
    logic [31:0] D_pc8;
    logic        f_err;
    logic [31:0] taken_cnt;
    logic [31:0] stall_cnt;

    logic [31:0] mem [0:WORDS-1];

    int tests = 0;
    int fails = 0;

    // reference model state
    logic [31:0] m_pc, m_di, m_dpc, m_tc, m_sc;
    logic        m_ferr;

    always #5 clk = ~clk;

    if_stage #(.PC_RESET(PCR), .IM_WORDS(WORDS)) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .br_type   (br_type),
        .cmp       (cmp),
        .jump      (jump),
        .jreg      (jreg),
        .ra        (ra),
        .im_addr   (im_addr),
        .im_instr  (im_instr),
        .D_instr   (D_instr),
        .D_pc      (D_pc),
        .D_pc8     (D_pc8),
        .f_err     (f_err),
        .taken_cnt (taken_cnt),
        .stall_cnt (stall_cnt)
    );

    // Memory answers for any address inside the window (even misaligned),
    // garbage elsewhere; the DUT must replace invalid fetches with a nop.
    always_comb begin
        if (im_addr >= PCR && im_addr < PCR + 4 * WORDS)
            im_instr = mem[(im_addr - PCR) >> 2];
        else
            im_instr = 32'hDEAD_BEEF;
    end

    function automatic logic in_range(input logic [31:0] a);
        return (a % 4 == 0) && (a >= PCR) && (longint'(a) < longint'(PCR) + 4 * WORDS);
    endfunction

    function automatic logic cond_met(input int kind, input int c);
        if (c == 3) return 1'b0;
        case (kind)
            1: return c == 0;
            2: return c != 0;
            3: return c != 2;
            4: return c == 1;
            5: return c != 1;
            6: return c == 2;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("im_addr",   im_addr,          m_pc);
        chk("D_instr",   D_instr,          m_di);
        chk("D_pc",      D_pc,             m_dpc);
        chk("D_pc8",     D_pc8,            m_dpc + 32'd8);
        chk("f_err",     {31'd0, f_err},   {31'd0, m_ferr});
        chk("taken_cnt", taken_cnt,        m_tc);
        chk("stall_cnt", stall_cnt,        m_sc);
    endtask

    // Called at a falling edge; returns at a falling edge with reset released.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        m_pc = PCR; m_di = 0; m_dpc = 0; m_ferr = 0; m_tc = 0; m_sc = 0;
        check_all();
        @(posedge clk); #1;
        check_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic step(input logic s, input logic [2:0] bt, input logic [1:0] c,
                        input logic j, input logic jr, input logic [31:0] a);
        logic [31:0] n_pc, n_di, n_dpc, n_tc, n_sc, tgt, seq;
        logic        n_ferr, tk;
        stall = s; br_type = bt; cmp = c; jump = j; jreg = jr; ra = a;
        n_pc = m_pc; n_di = m_di; n_dpc = m_dpc; n_ferr = m_ferr; n_tc = m_tc; n_sc = m_sc;
        if (s) begin
            n_sc = m_sc + 1;
        end else begin
            seq = m_dpc + 4;
            tk  = 1'b1;
            if (jr)                    tgt = a;
            else if (j)                tgt = {seq[31:28], m_di[25:0], 2'b00};
            else if (cond_met(bt, c))  tgt = seq + 32'(signed'(m_di[15:0])) * 4;
            else begin tk = 1'b0;      tgt = m_pc + 4; end
            n_pc   = tgt;
            n_dpc  = m_pc;
            n_ferr = !in_range(m_pc);
            n_di   = n_ferr ? 32'd0 : mem[(m_pc - PCR) / 4];
            if (tk) n_tc = m_tc + 1;
        end
        @(posedge clk); #1;
        m_pc = n_pc; m_di = n_di; m_dpc = n_dpc; m_ferr = n_ferr; m_tc = n_tc; m_sc = n_sc;
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        step(1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; br_type = 3'd0; cmp = 2'd0;
        jump = 1'b0; jreg = 1'b0; ra = 32'd0;
        for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
        mem[2] = 32'h1000_FFFE;
        @(negedge clk);

        // sequential fetch
        do_reset();
        chk("rst_addr", im_addr, 32'h3000);
        chk("rst_pc8",  D_pc8,   32'd8);
        idle(); idle(); idle();
        chk("seq_addr", im_addr, 32'h300C);
        chk("seq_dpc",  D_pc,    32'h3008);
        chk("seq_inst", D_instr, 32'h1000_FFFE);

        // beq taken backward, then delay slot, then target
        step(1'b0, 3'd1, 2'b00, 1'b0, 1'b0, 32'd0);
        chk("beq_tgt",  im_addr,   32'h3004);
        chk("beq_cnt",  taken_cnt, 32'd1);
        chk("beq_slot", D_pc,      32'h300C);
        idle();
        chk("beq_tgtD", D_pc,      32'h3004);

        // beq not taken
        do_reset();
        idle(); idle(); idle();
        step(1'b0, 3'd1, 2'b01, 1'b0, 1'b0, 32'd0);
        chk("beq_nt",     im_addr,   32'h3010);
        chk("beq_nt_cnt", taken_cnt, 32'd0);

        step(1'b0, 3'd3, 2'b10, 1'b0, 1'b0, 32'd0);
        chk("bgez_lt", taken_cnt, 32'd0);
        step(1'b0, 3'd6, 2'b10, 1'b0, 1'b0, 32'd0);
        chk("bltz_lt", taken_cnt, 32'd1);
        step(1'b0, 3'd2, 2'b11, 1'b0, 1'b0, 32'd0);
        chk("bne_bad", taken_cnt, 32'd1);

        // priority jreg > jump > branch
        step(1'b0, 3'd1, 2'b00, 1'b1, 1'b1, 32'h0000_3400);
        chk("prio_addr", im_addr,   32'h3400);
        chk("prio_cnt",  taken_cnt, 32'd2);

        // stall while a taken bne sits in D
        idle();
        for (int k = 0; k < 3; k++) step(1'b1, 3'd2, 2'b01, 1'b0, 1'b0, 32'd0);
        chk("stall_cnt3", stall_cnt, 32'd3);
        chk("stall_tc",   taken_cnt, 32'd2);
        step(1'b0, 3'd2, 2'b01, 1'b0, 1'b0, 32'd0);
        chk("stall_rel",  taken_cnt, 32'd3);

        // out-of-range and misaligned fetches
        step(1'b0, 3'd0, 2'd0, 1'b0, 1'b1, 32'h0000_3002);
        chk("mis_addr", im_addr, 32'h3002);
        idle();
        chk("mis_inst", D_instr, 32'd0);
        chk("mis_err",  {31'd0, f_err}, 32'd1);
        step(1'b0, 3'd0, 2'd0, 1'b0, 1'b1, PCR + 4 * WORDS);
        idle();
        chk("oor_inst", D_instr, 32'd0);
        chk("oor_err",  {31'd0, f_err}, 32'd1);
        step(1'b0, 3'd0, 2'd0, 1'b0, 1'b1, PCR + 4 * WORDS - 4);
        idle();
        chk("last_err", {31'd0, f_err}, 32'd0);

        // reset while stalled
        step(1'b1, 3'd1, 2'b00, 1'b0, 1'b0, 32'd0);
        do_reset();
        chk("rst_stall_sc", stall_cnt, 32'd0);
        chk("rst_stall_pc", im_addr,   32'h3000);
        stall = 1'b0;

        // random traffic
        for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(99) < 2) begin
                do_reset();
            end else begin
                step($urandom_range(99) < 20,
                     3'($urandom_range(7)),
                     2'($urandom_range(3)),
                     $urandom_range(99) < 5,
                     $urandom_range(99) < 15,
                     ($urandom_range(9) < 8) ? PCR + 4 * $urandom_range(WORDS - 1) : $urandom);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
